// File: rtl/sram_mem_ctrl_pkg.sv
// Shared memory-stage definitions: access FSM states, default SRAM byte base,
// SRAM word-address width and the byte-to-word address mapping.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;
  localparam int unsigned SRAM_AW           = 16;

  // Byte address to SRAM word address; underflow below the base wraps silently
  function automatic logic [SRAM_AW-1:0] word_addr(input logic [31:0] byte_addr,
                                                   input logic [31:0] base);
    return SRAM_AW'((byte_addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: sequences one fixed-latency SRAM read or write per
// request and holds ready low (pipeline freeze) until the access completes.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wr_flag;
  logic [31:0]        r_read_data;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [31:0]        r_sram_wdata;
  logic               r_we_n;
  logic               r_oe_n;
  logic               w_req;

  // A simultaneous load and store request is treated as a store
  assign w_req = rd_en | wr_en;

  // Access sequencer; strobes are registered from the transition being taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_wr_flag    <= 1'b0;
      r_read_data  <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_sram_addr  <= word_addr(address, ADDR_BASE);
            r_sram_wdata <= write_data;
            r_wr_flag    <= wr_en;
            r_cnt        <= '0;
            r_we_n       <= ~wr_en;
            r_oe_n       <= wr_en;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == CNT_LAST) begin
            if (!r_wr_flag) begin
              r_read_data <= sram_rdata;
            end
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Request inputs still show the finished access here, so never re-accept
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready      = ((r_state == IDLE) && !w_req) || (r_state == DONE);
  assign read_data  = r_read_data;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_we_n  = r_we_n;
  assign sram_oe_n  = r_oe_n;

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-stage controller between the EX/MEM pipeline register outputs and an external single-port SRAM with a fixed access latency. It accepts one read or write per request, sequences the SRAM control strobes for a programmable number of wait cycles, and returns load data. While an access is in flight it holds `ready` low; the pipeline uses `~ready` as its global freeze for every stage register, including EX/MEM.

## Interface
- `WAIT_CYCLES`, 5: SRAM cycles per access; legal range ≥1.
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `clk`  in  1  rising-edge clock for the whole block.
- `rst`  in  1  reset, synchronous and active-high.
- `rd_en`  in  1  load request, from the EX/MEM MEM_R_EN output.
- `wr_en`  in  1  store request, from the EX/MEM MEM_W_EN output.
- `address`  in  32  byte address, from the EX/MEM ALU result.
- `write_data`  in  32  store data, from the EX/MEM Val_Rm output.
- `read_data`  out  32  load data, valid while `ready`=1 in the DONE state.
- `ready`  out  1  1 = no access pending; pipeline may advance.
- `sram_addr`  out  16  SRAM word address.
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  32  SRAM read data.
- `sram_we_n`  out  1  SRAM write strobe, active-low.
- `sram_oe_n`  out  1  SRAM output enable, active-low.

## Operation
- `req` = `rd_en | wr_en`. If both inputs are 1, the access is a write; the read is dropped.
- Word address = `((address - ADDR_BASE) mod 2^32) >> 2`, truncated to 16 bits. `address[1:0]` is ignored. Underflow wraps with no error.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE with `req`=1: register the address, write data and a write flag. Clear the counter. Go to ACCESS.
  - ACCESS: the counter counts up from 0. When counter = `WAIT_CYCLES-1`, capture `sram_rdata` into `read_data` (reads only; writes leave `read_data` unchanged) and go to DONE. Otherwise increment the counter.
  - DONE: always go to IDLE after one cycle. No new request is accepted in DONE, because the pipeline advances on this edge and the request inputs still show the completed access.
- `ready` (combinational) = (IDLE and !`req`) or DONE.
- `sram_we_n` = 0 only in ACCESS when the write flag is set. `sram_oe_n` = 0 only in ACCESS when the write flag is clear. Both are 1 in all other states.
- `sram_addr` and `sram_wdata` are registered. They are updated only on acceptance in IDLE and stay stable through ACCESS and DONE.
- Counter width is `$clog2(WAIT_CYCLES+1)`.
- Reset values: state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_wdata` 0, write flag 0, `sram_we_n` 1, `sram_oe_n` 1. With `req` low, `ready` = 1.
- Reset asserted mid-access aborts the access. At the next edge all outputs take their reset values. No DONE cycle occurs, and `read_data` is not updated.

## Timing
- Request visible at cycle 0 while in IDLE: `ready`=0 in cycle 0 (combinational).
- Cycles 1..`WAIT_CYCLES`: state ACCESS, strobe active, `ready`=0.
- Cycle `WAIT_CYCLES+1`: state DONE, `ready`=1, `read_data` valid, strobes inactive.
- Total freeze is `WAIT_CYCLES+1` cycles per access.
- Back-to-back memory instructions: the earliest next acceptance is the cycle after DONE. IDLE is entered and the new request is accepted in that same cycle.
- Non-memory instructions: `ready` stays 1 and no freeze occurs.
- `sram_rdata` is sampled at the final ACCESS edge only. The SRAM model must drive valid data by then.

## Structure
- The shared pipeline package holds:
  - the `mem_state_t` enum (IDLE, ACCESS, DONE);
  - the `ADDR_BASE` default constant;
  - the SRAM address width (16).
- The block is a single module with no sub-module. The counter and FSM are small enough to be inline.

## Test plan
- Load at `address`=1024+8, `sram_rdata`=0xDEADBEEF, `WAIT_CYCLES`=5 → `sram_addr`=2; `sram_oe_n` low for exactly 5 cycles; `ready` low for 6 cycles; in cycle 6 `ready`=1 and `read_data`=0xDEADBEEF.
- Store at `address`=1024+4, `write_data`=0x12345678 → `sram_addr`=1; `sram_wdata`=0x12345678 stable; `sram_we_n` low 5 cycles; `oe_n` stays 1; `read_data` unchanged.
- Both `rd_en` and `wr_en` high → write performed; `sram_oe_n` never asserts.
- Two consecutive loads, with the inputs changing only when `ready`=1 → exactly two ACCESS phases, 6 freeze cycles each, no duplicate access from the DONE cycle.
- `rst` pulsed at the 3rd ACCESS cycle → next edge: IDLE, `we_n`/`oe_n`=1, `sram_addr`=0, `read_data`=0; with `req` low, `ready`=1.
- `address`=0 (below base) → `sram_addr`=(0−1024)>>2 truncated = 0xFF00; access completes normally.
